// File: rtl/valtrain_pkg.sv
// Shared constants for the VALTRAIN valid-lane pattern generator and detector.
// Both sides import these so the pattern definition lives in one place.
package valtrain_pkg;

    localparam logic [7:0]  VALID_8BIT = 8'hF0;
    localparam logic [31:0] VALID_WORD = 32'hF0F0F0F0;
    localparam int          WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_LOCK = 2'b01,
        ST_CHECK     = 2'b11,
        ST_DONE      = 2'b10
    } valtrain_state_e;

endpackage

// File: rtl/valtrain_byte_cmp.sv
// Counts how many bytes of a deserialized valid-lane word differ from the
// 8-bit valid pattern (0..4).
module valtrain_byte_cmp
    import valtrain_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [2:0]  o_mismatch_cnt
);

    always_comb begin
        o_mismatch_cnt = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i_word[8*i +: 8] != VALID_8BIT) begin
                o_mismatch_cnt = o_mismatch_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/valtrain_detector.sv
// Receive-side VALTRAIN checker: locks on the first valid word, then counts
// mismatching bytes over a fixed-length run and reports pass/fail/timeout.
module valtrain_detector
    import valtrain_pkg::*;
#(
    parameter int NUM_WORDS     = 32,
    parameter int ERR_THRESHOLD = 16,
    parameter int LOCK_TIMEOUT  = 64,
    parameter int ERR_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable_detector,
    input  logic [31:0]      i_RVLD_L,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_busy
);

    localparam int WC_W = $clog2(NUM_WORDS + 1);
    localparam int TM_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
    localparam logic [TM_W-1:0] LAST_WAIT = TM_W'(LOCK_TIMEOUT - 1);

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                                  input logic [2:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, acc} + {{(ERR_W-2){1'b0}}, inc};
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

    valtrain_state_e  state, state_nx;
    logic [WC_W-1:0]  word_cnt, word_cnt_nx;
    logic [TM_W-1:0]  lock_timer, lock_timer_nx;
    logic [ERR_W-1:0] err_cnt, err_cnt_nx;
    logic [ERR_W-1:0] err_sum;
    logic [ERR_W-1:0] err_out_nx;
    logic             pass_nx, timeout_nx, done_nx, busy_nx;
    logic [2:0]       mismatch_cnt;

    valtrain_byte_cmp u_byte_cmp (
        .i_word         (i_RVLD_L),
        .o_mismatch_cnt (mismatch_cnt)
    );

    assign err_sum = sat_add(err_cnt, mismatch_cnt);

    always_comb begin
        state_nx      = state;
        word_cnt_nx   = word_cnt;
        lock_timer_nx = lock_timer;
        err_cnt_nx    = err_cnt;
        err_out_nx    = o_err_count;
        pass_nx       = o_pass;
        timeout_nx    = o_timeout;

        unique case (state)
            ST_IDLE: begin
                if (i_enable_detector) begin
                    state_nx      = ST_WAIT_LOCK;
                    err_cnt_nx    = '0;
                    word_cnt_nx   = '0;
                    lock_timer_nx = '0;
                    err_out_nx    = '0;
                    pass_nx       = 1'b0;
                    timeout_nx    = 1'b0;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock word arriving on the last allowed cycle still wins.
                if (!i_enable_detector) begin
                    state_nx = ST_IDLE;
                end else if (i_RVLD_L == VALID_WORD) begin
                    state_nx    = ST_CHECK;
                    word_cnt_nx = WC_W'(1);
                end else if (lock_timer == LAST_WAIT) begin
                    state_nx   = ST_DONE;
                    timeout_nx = 1'b1;
                    pass_nx    = 1'b0;
                    err_out_nx = '0;
                end else begin
                    lock_timer_nx = lock_timer + TM_W'(1);
                end
            end
            ST_CHECK: begin
                if (!i_enable_detector) begin
                    state_nx = ST_IDLE;
                end else begin
                    err_cnt_nx  = err_sum;
                    word_cnt_nx = word_cnt + WC_W'(1);
                    if (word_cnt == LAST_WORD) begin
                        state_nx   = ST_DONE;
                        err_out_nx = err_sum;
                        pass_nx    = (int'(err_sum) <= ERR_THRESHOLD);
                    end
                end
            end
            ST_DONE: begin
                if (!i_enable_detector) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        busy_nx = (state_nx == ST_WAIT_LOCK) || (state_nx == ST_CHECK);
        done_nx = (state_nx == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            lock_timer  <= '0;
            err_cnt     <= '0;
            o_err_count <= '0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nx;
            word_cnt    <= word_cnt_nx;
            lock_timer  <= lock_timer_nx;
            err_cnt     <= err_cnt_nx;
            o_err_count <= err_out_nx;
            o_pass      <= pass_nx;
            o_timeout   <= timeout_nx;
            o_done      <= done_nx;
            o_busy      <= busy_nx;
        end
    end

endmodule
